// File: rtl/axi_lite_mem_bridge.sv
// AXI4-Lite slave to single-outstanding memory request/grant bridge.
// Independent one-deep AW/W/AR buffers, round-robin read/write service, address window decode.
module axi_lite_mem_bridge #(
    parameter int unsigned                AXI_ADDR_WIDTH = 64,
    parameter int unsigned                AXI_DATA_WIDTH = 64,
    parameter int unsigned                AXI_ID_WIDTH   = 10,
    parameter int unsigned                READ_LATENCY   = 1,
    parameter logic [AXI_ADDR_WIDTH-1:0]  ADDR_BASE      = '0,
    parameter logic [AXI_ADDR_WIDTH-1:0]  ADDR_SIZE      = 'h1000
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    // AW
    input  logic                          aw_valid,
    output logic                          aw_ready,
    input  logic [AXI_ADDR_WIDTH-1:0]     aw_addr,
    input  logic [AXI_ID_WIDTH-1:0]       aw_id,
    // W
    input  logic                          w_valid,
    output logic                          w_ready,
    input  logic [AXI_DATA_WIDTH-1:0]     w_data,
    input  logic [AXI_DATA_WIDTH/8-1:0]   w_strb,
    // B
    output logic                          b_valid,
    input  logic                          b_ready,
    output logic [1:0]                    b_resp,
    output logic [AXI_ID_WIDTH-1:0]       b_id,
    // AR
    input  logic                          ar_valid,
    output logic                          ar_ready,
    input  logic [AXI_ADDR_WIDTH-1:0]     ar_addr,
    input  logic [AXI_ID_WIDTH-1:0]       ar_id,
    // R
    output logic                          r_valid,
    input  logic                          r_ready,
    output logic [AXI_DATA_WIDTH-1:0]     r_data,
    output logic [1:0]                    r_resp,
    output logic [AXI_ID_WIDTH-1:0]       r_id,
    output logic                          r_last,
    // memory side
    output logic                          req_o,
    input  logic                          gnt_i,
    output logic                          we_o,
    output logic [AXI_ADDR_WIDTH-1:0]     addr_o,
    output logic [AXI_DATA_WIDTH/8-1:0]   be_o,
    output logic [AXI_DATA_WIDTH-1:0]     wdata_o,
    input  logic [AXI_DATA_WIDTH-1:0]     rdata_i
);

    localparam int unsigned STRB_W = AXI_DATA_WIDTH / 8;
    localparam logic [AXI_ADDR_WIDTH-1:0] ALIGN_MASK = ~AXI_ADDR_WIDTH'(STRB_W - 1);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] WR_REQ  = 3'd1;
    localparam logic [2:0] WR_RESP = 3'd2;
    localparam logic [2:0] RD_REQ  = 3'd3;
    localparam logic [2:0] RD_WAIT = 3'd4;
    localparam logic [2:0] RD_RESP = 3'd5;

    logic [2:0]                state_q;
    logic                      prio_rd_q;
    logic [2:0]                lat_cnt_q;

    logic                      aw_full_q, w_full_q, ar_full_q;
    logic                      aw_ready_q, w_ready_q, ar_ready_q;
    logic [AXI_ADDR_WIDTH-1:0] aw_addr_q, ar_addr_q;
    logic [AXI_ID_WIDTH-1:0]   aw_id_q, ar_id_q;
    logic [AXI_DATA_WIDTH-1:0] w_data_q;
    logic [STRB_W-1:0]         w_strb_q;

    logic [1:0]                b_resp_q, r_resp_q;
    logic [AXI_ID_WIDTH-1:0]   b_id_q, r_id_q;
    logic [AXI_DATA_WIDTH-1:0] r_data_q;

    logic                      aw_hs, w_hs, ar_hs;
    logic                      aw_have, w_have, ar_have;
    logic [AXI_ADDR_WIDTH-1:0] aw_addr_e, ar_addr_e;
    logic [AXI_ID_WIDTH-1:0]   aw_id_e, ar_id_e;
    logic                      wr_elig, rd_elig, pick_wr, pick_rd;
    logic                      wr_ok, rd_ok, wr_done, rd_done;
    logic                      aw_full_d, w_full_d, ar_full_d;
    logic [AXI_ADDR_WIDTH:0]   win_lo, win_hi;

    assign aw_hs = aw_valid & aw_ready_q;
    assign w_hs  = w_valid  & w_ready_q;
    assign ar_hs = ar_valid & ar_ready_q;

    // A beat handshaking this cycle is already visible to IDLE, so service starts one cycle earlier.
    assign aw_have   = aw_full_q | aw_hs;
    assign w_have    = w_full_q  | w_hs;
    assign ar_have   = ar_full_q | ar_hs;
    assign aw_addr_e = aw_full_q ? aw_addr_q : aw_addr;
    assign aw_id_e   = aw_full_q ? aw_id_q   : aw_id;
    assign ar_addr_e = ar_full_q ? ar_addr_q : ar_addr;
    assign ar_id_e   = ar_full_q ? ar_id_q   : ar_id;

    assign wr_elig = aw_have & w_have;
    assign rd_elig = ar_have;
    assign pick_wr = (state_q == IDLE) & wr_elig & (~rd_elig | ~prio_rd_q);
    assign pick_rd = (state_q == IDLE) & rd_elig & ~pick_wr;

    // One extra bit so a window ending past the top of the address space does not wrap.
    assign win_lo = {1'b0, ADDR_BASE};
    assign win_hi = win_lo + {1'b0, ADDR_SIZE};
    assign wr_ok  = ({1'b0, aw_addr_e} >= win_lo) && ({1'b0, aw_addr_e} < win_hi);
    assign rd_ok  = ({1'b0, ar_addr_e} >= win_lo) && ({1'b0, ar_addr_e} < win_hi);

    // Buffers free on memory grant, or immediately when the access is rejected by the decoder.
    assign wr_done   = ((state_q == WR_REQ) & gnt_i) | (pick_wr & ~wr_ok);
    assign rd_done   = ((state_q == RD_REQ) & gnt_i) | (pick_rd & ~rd_ok);
    assign aw_full_d = aw_have & ~wr_done;
    assign w_full_d  = w_have  & ~wr_done;
    assign ar_full_d = ar_have & ~rd_done;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            aw_full_q  <= 1'b0;
            w_full_q   <= 1'b0;
            ar_full_q  <= 1'b0;
            aw_ready_q <= 1'b0;
            w_ready_q  <= 1'b0;
            ar_ready_q <= 1'b0;
            aw_addr_q  <= '0;
            aw_id_q    <= '0;
            w_data_q   <= '0;
            w_strb_q   <= '0;
            ar_addr_q  <= '0;
            ar_id_q    <= '0;
        end else begin
            aw_full_q  <= aw_full_d;
            w_full_q   <= w_full_d;
            ar_full_q  <= ar_full_d;
            aw_ready_q <= ~aw_full_d;
            w_ready_q  <= ~w_full_d;
            ar_ready_q <= ~ar_full_d;
            if (aw_hs) begin
                aw_addr_q <= aw_addr;
                aw_id_q   <= aw_id;
            end
            if (w_hs) begin
                w_data_q <= w_data;
                w_strb_q <= w_strb;
            end
            if (ar_hs) begin
                ar_addr_q <= ar_addr;
                ar_id_q   <= ar_id;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            prio_rd_q <= 1'b0;
            lat_cnt_q <= '0;
            b_resp_q  <= '0;
            b_id_q    <= '0;
            r_resp_q  <= '0;
            r_id_q    <= '0;
            r_data_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_wr) begin
                        b_id_q <= aw_id_e;
                        if (rd_elig) prio_rd_q <= 1'b1;
                        if (wr_ok) begin
                            b_resp_q <= RESP_OKAY;
                            state_q  <= WR_REQ;
                        end else begin
                            b_resp_q <= RESP_SLVERR;
                            state_q  <= WR_RESP;
                        end
                    end else if (pick_rd) begin
                        r_id_q <= ar_id_e;
                        if (wr_elig) prio_rd_q <= 1'b0;
                        if (rd_ok) begin
                            r_resp_q <= RESP_OKAY;
                            state_q  <= RD_REQ;
                        end else begin
                            r_resp_q <= RESP_SLVERR;
                            r_data_q <= '0;
                            state_q  <= RD_RESP;
                        end
                    end
                end
                WR_REQ:  if (gnt_i) state_q <= WR_RESP;
                WR_RESP: if (b_ready) state_q <= IDLE;
                RD_REQ: begin
                    if (gnt_i) begin
                        lat_cnt_q <= 3'(READ_LATENCY - 1);
                        state_q   <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (lat_cnt_q == 3'd0) begin
                        r_data_q <= rdata_i;
                        state_q  <= RD_RESP;
                    end else begin
                        lat_cnt_q <= lat_cnt_q - 3'd1;
                    end
                end
                RD_RESP: if (r_ready) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign aw_ready = aw_ready_q;
    assign w_ready  = w_ready_q;
    assign ar_ready = ar_ready_q;

    // Request fields come straight from full buffers, so they cannot move while stalled.
    assign req_o   = (state_q == WR_REQ) | (state_q == RD_REQ);
    assign we_o    = (state_q == WR_REQ);
    assign addr_o  = (state_q == RD_REQ) ? (ar_addr_q & ALIGN_MASK) :
                     (state_q == WR_REQ) ? (aw_addr_q & ALIGN_MASK) : '0;
    assign be_o    = (state_q == RD_REQ) ? {STRB_W{1'b1}} :
                     (state_q == WR_REQ) ? w_strb_q : '0;
    assign wdata_o = (state_q == WR_REQ) ? w_data_q : '0;

    assign b_valid = (state_q == WR_RESP);
    assign b_resp  = b_resp_q;
    assign b_id    = b_id_q;
    assign r_valid = (state_q == RD_RESP);
    assign r_data  = r_data_q;
    assign r_resp  = r_resp_q;
    assign r_id    = r_id_q;
    assign r_last  = r_valid;

endmodule

// File: tb/tb_axi_lite_mem_bridge.sv
// Scoreboard bench for axi_lite_mem_bridge: expected responses queued at issue, checked by a monitor.
module tb_axi_lite_mem_bridge;

    localparam int          RL   = 3;
    localparam logic [63:0] BASE = 64'h0;
    localparam logic [63:0] SIZE = 64'h1000;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        aw_valid = 0, w_valid = 0, ar_valid = 0;
    logic        aw_ready, w_ready, ar_ready;
    logic [63:0] aw_addr = 0, ar_addr = 0, w_data = 0;
    logic [9:0]  aw_id = 0, ar_id = 0;
    logic [7:0]  w_strb = 0;
    logic        b_valid, r_valid, r_last;
    logic        b_ready = 0, r_ready = 0;
    logic [1:0]  b_resp, r_resp;
    logic [9:0]  b_id, r_id;
    logic [63:0] r_data;
    logic        req_o, we_o;
    logic        gnt_i = 0;
    logic [63:0] addr_o, wdata_o;
    logic [7:0]  be_o;
    logic [63:0] rdata_i = 0;

    axi_lite_mem_bridge #(
        .AXI_ADDR_WIDTH(64), .AXI_DATA_WIDTH(64), .AXI_ID_WIDTH(10),
        .READ_LATENCY(RL), .ADDR_BASE(BASE), .ADDR_SIZE(SIZE)
    ) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_addr(aw_addr), .aw_id(aw_id),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_strb(w_strb),
        .b_valid(b_valid), .b_ready(b_ready), .b_resp(b_resp), .b_id(b_id),
        .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_addr(ar_addr), .ar_id(ar_id),
        .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_resp(r_resp),
        .r_id(r_id), .r_last(r_last),
        .req_o(req_o), .gnt_i(gnt_i), .we_o(we_o), .addr_o(addr_o), .be_o(be_o),
        .wdata_o(wdata_o), .rdata_i(rdata_i)
    );

    always #5 clk = ~clk;

    typedef struct { logic [63:0] addr; logic [7:0] be; logic [63:0] data; } wreq_t;
    typedef struct { logic [9:0] id; logic [1:0] resp; logic [63:0] data; } rsp_t;

    wreq_t       wreq_q[$];
    logic [63:0] rreq_q[$];
    rsp_t        b_q[$];
    rsp_t        r_q[$];
    bit          order_q[$];
    bit          order_rec = 0;

    int tests = 0;
    int fails = 0;
    int gnt_mode = 0;   // 0: always grant, 1: random, 2: hold low
    bit rdy_rand = 0;
    bit rdy_fix  = 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Memory contents are a fixed function of the word address.
    function automatic logic [63:0] mem_fn(input logic [63:0] a);
        return {a[31:0] ^ 32'hC001_D00D, ~a[31:0]};
    endfunction

    function automatic bit in_rng(input logic [63:0] a);
        return (a >= BASE) && ((a - BASE) < SIZE);
    endfunction

    function automatic logic [63:0] rand_addr();
        case ($urandom_range(0, 9))
            0: return SIZE;
            1: return BASE - 64'd8;
            2: return {$urandom, $urandom} | 64'h8000_0000_0000_0000;
            3: return 64'hFF8;
            default: return 64'($urandom_range(0, 'hFFF));
        endcase
    endfunction

    // Memory-side inputs and AXI ready change just after the edge so each cycle sees stable values.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (gnt_mode)
                0: gnt_i = 1'b1;
                1: gnt_i = ($urandom_range(0, 2) != 0);
                default: gnt_i = 1'b0;
            endcase
            b_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_fix;
            r_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_fix;
        end
    end

    // Monitor: memory responder plus scoreboard pops; everything sampled mid-cycle.
    initial begin
        int          rd_cnt = 0;
        logic [63:0] rd_addr = 0;
        bit          p_stall = 0, pb = 0, pr = 0;
        logic [73:0] p_ctl = 0;
        logic [63:0] p_wd = 0;
        logic [11:0] p_b = 0;
        logic [75:0] p_r = 0;
        wreq_t       ew;
        logic [63:0] ea;
        rsp_t        er;
        forever begin
            @(negedge clk);
            if (!rst_ni) begin
                rd_cnt = 0; p_stall = 0; pb = 0; pr = 0;
            end else begin
                if (p_stall) begin
                    chk("req_hold", {req_o, we_o, be_o, addr_o}, p_ctl);
                    chk("wdata_hold", wdata_o, p_wd);
                end
                if (pb) chk("b_hold", {b_valid, b_id, b_resp}, {1'b0, p_b} | (75'(1) << 12));
                if (pr) chk("r_hold", {r_valid, r_id, r_resp, r_data}, {1'b1, p_r});
                if (rd_cnt > 0) begin
                    rd_cnt--;
                    rdata_i = (rd_cnt == 0) ? mem_fn(rd_addr) : {$urandom, $urandom};
                end else begin
                    rdata_i = {$urandom, $urandom};
                end
                if (req_o && gnt_i) begin
                    if (order_rec) order_q.push_back(we_o);
                    if (we_o) begin
                        chk("wr_req_expected", wreq_q.size() != 0, 1'b1);
                        if (wreq_q.size() != 0) begin
                            ew = wreq_q.pop_front();
                            chk("wr_addr", addr_o, ew.addr);
                            chk("wr_be", be_o, ew.be);
                            chk("wr_data", wdata_o, ew.data);
                        end
                    end else begin
                        chk("rd_req_expected", rreq_q.size() != 0, 1'b1);
                        if (rreq_q.size() != 0) begin
                            ea = rreq_q.pop_front();
                            chk("rd_addr", addr_o, ea);
                            chk("rd_be", be_o, 8'hFF);
                        end
                        rd_cnt  = RL;
                        rd_addr = addr_o;
                    end
                end
                if (b_valid && b_ready) begin
                    chk("b_expected", b_q.size() != 0, 1'b1);
                    if (b_q.size() != 0) begin
                        er = b_q.pop_front();
                        chk("b_id", b_id, er.id);
                        chk("b_resp", b_resp, er.resp);
                    end
                end
                if (r_valid && r_ready) begin
                    chk("r_expected", r_q.size() != 0, 1'b1);
                    if (r_q.size() != 0) begin
                        er = r_q.pop_front();
                        chk("r_id", r_id, er.id);
                        chk("r_resp", r_resp, er.resp);
                        chk("r_data", r_data, er.data);
                        chk("r_last", r_last, 1'b1);
                    end
                end
                p_stall = req_o && !gnt_i;
                p_ctl   = {req_o, we_o, be_o, addr_o};
                p_wd    = wdata_o;
                pb      = b_valid && !b_ready;
                p_b     = {b_id, b_resp};
                pr      = r_valid && !r_ready;
                p_r     = {r_id, r_resp, r_data};
            end
        end
    end

    task automatic exp_wr(input logic [63:0] a, input logic [63:0] d, input logic [7:0] be,
                          input logic [9:0] id);
        if (in_rng(a)) wreq_q.push_back('{a & ~64'h7, be, d});
        b_q.push_back('{id, in_rng(a) ? 2'b00 : 2'b10, 64'h0});
    endtask

    task automatic exp_rd(input logic [63:0] a, input logic [9:0] id);
        if (in_rng(a)) rreq_q.push_back(a & ~64'h7);
        r_q.push_back('{id, in_rng(a) ? 2'b00 : 2'b10, in_rng(a) ? mem_fn(a & ~64'h7) : 64'h0});
    endtask

    // Channel drivers: called at a negedge, return at the negedge after the handshake edge.
    task automatic do_aw(input logic [63:0] a, input logic [9:0] id);
        int n = 0;
        aw_addr = a; aw_id = id; aw_valid = 1'b1;
        while (!aw_ready && n < 400) begin @(negedge clk); n++; end
        chk("aw_hs_in_time", n < 400, 1'b1);
        @(negedge clk);
        aw_valid = 1'b0;
    endtask

    task automatic do_w(input logic [63:0] d, input logic [7:0] be);
        int n = 0;
        w_data = d; w_strb = be; w_valid = 1'b1;
        while (!w_ready && n < 400) begin @(negedge clk); n++; end
        chk("w_hs_in_time", n < 400, 1'b1);
        @(negedge clk);
        w_valid = 1'b0;
    endtask

    task automatic do_ar(input logic [63:0] a, input logic [9:0] id);
        int n = 0;
        ar_addr = a; ar_id = id; ar_valid = 1'b1;
        while (!ar_ready && n < 400) begin @(negedge clk); n++; end
        chk("ar_hs_in_time", n < 400, 1'b1);
        @(negedge clk);
        ar_valid = 1'b0;
    endtask

    task automatic wr(input logic [63:0] a, input logic [63:0] d, input logic [7:0] be,
                      input logic [9:0] id, input int aw_dly, input int w_dly);
        exp_wr(a, d, be, id);
        fork
            begin repeat (aw_dly) @(negedge clk); do_aw(a, id); end
            begin repeat (w_dly) @(negedge clk); do_w(d, be); end
        join
    endtask

    task automatic rd(input logic [63:0] a, input logic [9:0] id);
        exp_rd(a, id);
        do_ar(a, id);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((b_q.size() + r_q.size() + wreq_q.size() + rreq_q.size() != 0 || b_valid || r_valid)
               && n < 3000) begin
            @(negedge clk); n++;
        end
        chk(name, b_q.size() + r_q.size() + wreq_q.size() + rreq_q.size(), 0);
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        aw_valid = 0; w_valid = 0; ar_valid = 0;
        wreq_q.delete(); rreq_q.delete(); b_q.delete(); r_q.delete();
        repeat (2) @(negedge clk);
        chk("rst_handshakes", {aw_ready, w_ready, ar_ready, req_o, b_valid, r_valid, r_last}, 7'b0);
        chk("rst_resp_regs", {b_resp, r_resp, b_id, r_id}, 24'h0);
        chk("rst_rdata_reg", r_data, 64'h0);
        rst_ni = 1'b1;
        @(negedge clk);
        chk("post_rst_buffers_empty", {aw_ready, w_ready, ar_ready}, 3'b111);
    endtask

    initial begin
        int n;
        @(negedge clk);
        do_reset();

        // Same-cycle AW+W, request the cycle after, B the cycle after that
        gnt_mode = 0; rdy_rand = 0; rdy_fix = 1;
        wr(64'h10, 64'hDEAD_BEEF, 8'h0F, 10'h123, 0, 0);
        chk("t1_req_next_cycle", {req_o, we_o}, 2'b11);
        @(negedge clk);
        chk("t1_bvalid_two_cycles", b_valid, 1'b1);
        drain("t1_drain");

        // Unstalled read latency
        rd(64'h100, 10'd7);
        n = 0;
        while (!r_valid && n < 20) begin @(negedge clk); n++; end
        chk("rd_latency", n, RL + 1);
        drain("rd_lat_drain");

        // W first, AW three cycles later
        exp_wr(64'h48, 64'h0123_4567_89AB_CDEF, 8'hF0, 10'h2A);
        do_w(64'h0123_4567_89AB_CDEF, 8'hF0);
        repeat (3) begin
            chk("t2_no_req_without_aw", req_o, 1'b0);
            chk("t2_wready_low", w_ready, 1'b0);
            @(negedge clk);
        end
        do_aw(64'h48, 10'h2A);
        chk("t2_req_after_aw", {req_o, we_o, w_ready}, 3'b110);
        @(negedge clk);
        chk("t2_wready_after_gnt", {w_ready, b_valid}, 2'b11);
        drain("t2_drain");

        // Grant withheld for four cycles
        gnt_mode = 2;
        rd(64'h8, 10'd5);
        repeat (4) begin
            chk("t3_req_held", {req_o, we_o}, 2'b10);
            @(negedge clk);
        end
        gnt_mode = 0;
        @(negedge clk);
        chk("t3_grant_cycle", req_o & gnt_i, 1'b1);
        n = 0;
        while (!r_valid && n < 20) begin @(negedge clk); n++; end
        chk("t3_rvalid_after_gnt", n, RL + 1);
        drain("t3_drain");

        // Decode boundaries
        rd(SIZE, 10'd9);
        chk("t4_oor_read_no_req", {req_o, r_valid}, 2'b01);
        drain("t4_rd_drain");
        wr(BASE - 64'd8, 64'h55, 8'hFF, 10'd11, 0, 0);
        chk("t4_oor_write_no_req", {req_o, b_valid}, 2'b01);
        drain("t4_wr_drain");
        rd(SIZE - 64'd8, 10'd12);
        drain("t4_last_word_drain");

        // Randomised traffic under random grant and ready
        gnt_mode = 1; rdy_rand = 1;
        fork
            repeat (20) wr(rand_addr(), {$urandom, $urandom}, 8'($urandom_range(0, 255)),
                           10'($urandom_range(0, 1023)), $urandom_range(0, 3), $urandom_range(0, 3));
            repeat (20) begin
                repeat ($urandom_range(0, 3)) @(negedge clk);
                rd(rand_addr(), 10'($urandom_range(0, 1023)));
            end
        join
        drain("rand_drain");

        // Arbitration order from reset with both sides always pending
        gnt_mode = 0; rdy_rand = 0; rdy_fix = 1;
        do_reset();
        order_q.delete();
        order_rec = 1;
        fork
            for (int i = 0; i < 3; i++) wr(64'h200 + 64'(i * 8), {$urandom, $urandom}, 8'hFF, 10'(i), 0, 0);
            for (int i = 0; i < 3; i++) rd(64'h300 + 64'(i * 8), 10'(16 + i));
        join
        drain("t5_drain");
        order_rec = 0;
        chk("t5_grant_count", order_q.size(), 6);
        for (int i = 0; i < order_q.size() && i < 6; i++)
            chk("t5_order", order_q[i], (i % 2) == 0);

        // Reset during RD_WAIT
        rd(64'h30, 10'd3);
        @(negedge clk);
        chk("t6_in_rd_wait", {req_o, r_valid}, 2'b00);
        do_reset();
        repeat (8) @(negedge clk);
        chk("t6_no_stale_r", r_valid, 1'b0);

        // Reset while B stalled
        rdy_fix = 0;
        wr(64'h20, 64'h77, 8'h01, 10'd4, 0, 0);
        n = 0;
        while (!b_valid && n < 20) begin @(negedge clk); n++; end
        chk("t6_b_pending", b_valid, 1'b1);
        repeat (2) @(negedge clk);
        do_reset();
        rdy_fix = 1;
        repeat (4) @(negedge clk);
        chk("t6_no_stale_b", b_valid, 1'b0);
        rd(64'h40, 10'd6);
        drain("t6_fresh_read");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #800000;
        fails++;
        $display("FAIL global_timeout: simulation did not complete by %0t", $time);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
